// File: rtl/mac_dot_seq.sv
// Operand sequencer for the 4-lane int8 MAC: streams word pairs into the MAC,
// feeds the running partial sum back as p and returns the final sum over valid/ready.
module mac_dot_seq #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_last,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    output logic [7:0]       mac_p,
    input  logic [7:0]       mac_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [LEN_W-1:0] out_len,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       acc;
    logic [LEN_W-1:0] cnt;
    logic             load;
    logic             accept;
    logic             ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        accept    = 1'b0;
        ovf       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_last) begin
                        state_nxt = DONE;
                    end else if (cnt == CNT_MAX) begin
                        ovf       = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (start) begin
                        load      = 1'b1;
                        state_nxt = ACC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // err is sticky across DONE/IDLE and only clears on an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (load) begin
            acc <= bias;
            cnt <= '0;
            err <= 1'b0;
        end else if (accept) begin
            acc <= mac_c;
            cnt <= cnt + LEN_W'(1);
            if (ovf) err <= 1'b1;
        end
    end

    assign mac_p    = acc;
    assign mac_a    = (state == ACC) ? in_a : 32'h0;
    assign mac_b    = (state == ACC) ? in_b : 32'h0;
    assign out_data = acc;
    assign out_len  = cnt;
    assign busy     = (state != IDLE);

endmodule
